// File: rtl/limn2600_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : limn2600_bus_pkg
// Purpose : Shared definitions for the Limn2600 bus master. The package holds
//           the FSM state encoding, the word-alignment value, the default
//           WAIT timeout and a small alignment helper.
// Revision: 1.0 - initial release
// ============================================================================
package limn2600_bus_pkg;

    // Default number of WAIT cycles allowed before an access is aborted.
    localparam int unsigned c_TIMEOUT_CYCLES_DEFAULT = 16;

    // The low two address bits of a word-aligned access.
    localparam logic [1:0] c_WORD_ALIGN = 2'b00;

    // FSM state encoding.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    // Takes only the low address bits, so callers slice the address.
    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return addr_lo == c_WORD_ALIGN;
    endfunction

endpackage
`default_nettype wire

// File: rtl/limn2600_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module  : limn2600_bus_timeout
// Purpose : WAIT-state watchdog counter. Cleared on entry to WAIT, counts
//           each WAIT cycle in which the memory has not answered, and flags
//           expiry in the cycle where the count reaches TIMEOUT_CYCLES-1.
// Ports   : clk     - clock, rising edge
//           rst     - synchronous active-low reset
//           clear   - restart the count from zero
//           enable  - count this cycle (WAIT without rdy)
//           expired - count has reached TIMEOUT_CYCLES-1
// Revision: 1.0 - initial release
// ============================================================================
module limn2600_bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    c_CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);

    logic [c_CW-1:0] r_count;

    assign expired = (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            // Held at the last value once expired; the FSM leaves WAIT then.
            r_count <= r_count + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/limn2600_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : limn2600_bus_master
// Purpose : Bridges a valid/ready CPU request/response channel onto a simple
//           select/write-enable memory bus with a completion pulse (rdy).
//           FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Misaligned requests
//           skip the bus and answer with an error straight away.
// Config  : LIMN2600_BUSM_TIMEOUT_EN - when defined, an access whose rdy does
//           not arrive within TIMEOUT_CYCLES WAIT cycles ends with rsp_err=1.
// Ports   : clk, rst (sync, active-low)
//           req_valid/req_ready/req_we/req_addr/req_wdata - CPU request
//           rsp_valid/rsp_ready/rsp_rdata/rsp_err         - CPU response
//           cs/we/addr/data_out/data_in/rdy               - memory bus
// Revision: 1.0 - initial release
// ============================================================================
module limn2600_bus_master
    import limn2600_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  cs,
    output logic                  we,
    output logic [31:0]           addr,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rdy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("limn2600_bus_master: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]            r_state;
    logic                  r_cs;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

`ifdef LIMN2600_BUSM_TIMEOUT_EN
    logic w_tmo_clear;
    logic w_tmo_enable;
    logic w_tmo_expired;

    // ISSUE always precedes WAIT, so clearing there restarts the count on entry.
    assign w_tmo_clear  = (r_state == c_ST_ISSUE);
    assign w_tmo_enable = (r_state == c_ST_WAIT) && !rdy;

    limn2600_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_tmo_clear),
        .enable (w_tmo_enable),
        .expired(w_tmo_expired)
    );
`endif

    assign req_ready = (r_state == c_ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign cs        = r_cs;
    assign we        = r_we;
    assign addr      = r_addr;
    assign data_out  = r_data_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data_out  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_we       <= req_we;
                        r_data_out <= req_wdata;
                        if (!is_word_aligned(req_addr[1:0])) begin
                            // Never reaches the bus: answer with an error now.
                            r_state     <= c_ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state <= c_ST_ISSUE;
                            r_cs    <= 1'b1;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_cs    <= 1'b0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // rdy is checked first so it wins over a same-cycle timeout.
                    if (rdy) begin
                        r_state     <= c_ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? '0 : data_in;
                    end
`ifdef LIMN2600_BUSM_TIMEOUT_EN
                    else if (w_tmo_expired) begin
                        r_state     <= c_ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
`endif
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/limn2600_bus_master.md
LIMN2600_BUS_MASTER -- requirements
Module: limn2600_bus_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the bus data words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, the number of WAIT cycles allowed before an access is aborted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: the CPU side presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: a response is held.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the CPU side consumes the response.
REQ-012 SHALL have port rsp_rdata, output, DATA_WIDTH bits: read data.
REQ-013 SHALL have port rsp_err, output, 1 bit: the access failed.
REQ-014 SHALL have port cs, output, 1 bit: memory-bus select.
REQ-015 SHALL have port we, output, 1 bit: memory-bus write enable.
REQ-016 SHALL have port addr, output, 32 bits: memory-bus address.
REQ-017 SHALL have port data_out, output, DATA_WIDTH bits: write data driven to the memory.
REQ-018 SHALL have port data_in, input, DATA_WIDTH bits: read data returned by the memory.
REQ-019 SHALL have port rdy, input, 1 bit: the memory completion pulse.

Function
REQ-020 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all bus and response outputs SHALL be registered.
REQ-021 IDLE: req_ready=1 (combinational from state). On req_valid&&req_ready it SHALL latch req_we, req_addr and req_wdata into addr, we and data_out.
REQ-022 Acceptance routing: if req_addr[1:0]!=0, go to RESP with rsp_err=1 and rsp_rdata=0, and cs SHALL never assert; otherwise go to ISSUE.
REQ-023 ISSUE: cs=1 for exactly one cycle, then go to WAIT; cs SHALL be 0 in every other state, so the memory never sees a repeated select.
REQ-024 WAIT: on rdy=1, capture rsp_rdata = data_in for reads (0 for writes), set rsp_err=0 and go to RESP.
REQ-025 Nominal latency: accept at edge N, cs high in cycle N+1, rdy in cycle N+2, rsp_valid high from cycle N+3.
REQ-026 RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready=1, then go to IDLE; no new request is accepted in the same cycle.
REQ-027 rdy seen in IDLE, ISSUE or RESP SHALL be ignored and SHALL NOT alter the response.
REQ-028 addr, we and data_out SHALL hold their last values outside ISSUE/WAIT; no bus glitching.

Reset
REQ-029 While rst=0 at a clock edge, the block SHALL enter IDLE with cs=0, we=0, addr=0, data_out=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the timeout counter at 0.
REQ-030 Reset in any state, including WAIT with a pending rdy, SHALL drop the transaction silently: no rsp_valid, and a later rdy is ignored.

Configuration
REQ-031 Macro LIMN2600_BUSM_TIMEOUT_EN, when defined: a counter SHALL clear on entry to WAIT and increment each WAIT cycle without rdy; at count==TIMEOUT_CYCLES-1 without rdy, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-032 Macro LIMN2600_BUSM_TIMEOUT_EN, when undefined: no counter logic SHALL exist, and WAIT SHALL persist until rdy arrives.
REQ-033 rdy arriving in the same cycle as the timeout SHALL win, giving a normal response.

Structure
REQ-034 Package limn2600_bus_pkg SHALL hold the FSM state encoding, the word-alignment mask (2'b00) and the default TIMEOUT_CYCLES constant.
REQ-035 Sub-module limn2600_bus_timeout (clear/enable/expired) SHALL be instantiated only under LIMN2600_BUSM_TIMEOUT_EN.

Verification
REQ-036 Read: req addr=0x00000010 with the memory returning 0xDEADBEEF on rdy in the cycle after cs -> cs high 1 cycle, rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Write: addr=0x00000020, wdata=0x12345678 -> cs=1, we=1, data_out=0x12345678 for 1 cycle; response rsp_rdata=0, rsp_err=0.
REQ-038 Misaligned: addr=0x00000013 -> cs stays 0 throughout; rsp_valid next cycle with rsp_err=1.
REQ-039 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0; req_ready=1 the cycle after the handshake.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES=16): rdy never asserted -> rsp_err=1 after 16 WAIT cycles; rdy arriving in cycle 16 -> normal response.
REQ-041 Reset in WAIT then a stray rdy -> no rsp_valid, all outputs at reset values, and the next request completes normally.
